// File: rtl/ttl_pkg.sv
// ttl_pkg
//   Shared definitions for the registered bus transceiver family.
//   XCVR_A2B / XCVR_B2A give the meaning of each bit of the per-bit
//   direction vector, so the top never hard-codes a bare 1'b1 / 1'b0.
package ttl_pkg;

    // Direction encoding for one bit of the dir vector
    localparam logic XCVR_A2B = 1'b1;
    localparam logic XCVR_B2A = 1'b0;

    // Build an all-ones or all-zeros XOR mask for the optional bus inversion
    function automatic logic [63:0] invert_mask(input int invert);
        return (invert != 0) ? {64{1'b1}} : {64{1'b0}};
    endfunction

endpackage

// File: rtl/ttl_xcvr_shreg.sv
// ttl_xcvr_shreg
//   DEPTH-stage storage pipeline for one transfer direction.
//   When en is high at a rising clk edge the word on d enters stage 0
//   and every other stage takes the word from the stage before it;
//   when en is low the pipeline holds. q is the oldest stage, so a word
//   appears on q after DEPTH enabled edges.
// Ports
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low, clears every stage, beats en
//   en    : shift enable
//   d     : word captured into stage 0
//   q     : last stage (stored data)
module ttl_xcvr_shreg
    import ttl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Storage pipeline: reset clears every stage even if en is high;
    // otherwise en acts as a pure clock enable for the whole chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/ttl_reg_xcvr.sv
// ttl_reg_xcvr
//   Registered bus transceiver (74x652 style) between two tristate buses.
//   Each bit transfers in one direction chosen by dir[i]; the driven value
//   is either the live opposite bus or the stored word of that direction's
//   pipeline, optionally inverted. The output path is purely combinational.
//   The pipelines sample the bus pins as seen, including this block's own
//   drive, so a bit captured while driven loops its own output back in.
// Ports
//   clk   : clock for both storage pipelines
//   rst_n : synchronous reset, active low, clears the pipelines only
//   a, b  : the two buses (inout, WIDTH bits)
//   dir   : per-bit direction, 1 = A->B, 0 = B->A
//   gab_n : A->B output enable, active low
//   gba_n : B->A output enable, active low
//   ldab  : shift bus A into the AB pipeline at the clock edge
//   ldba  : shift bus B into the BA pipeline at the clock edge
//   sab   : source for B, 0 = live A, 1 = AB stored word
//   sba   : source for A, 0 = live B, 1 = BA stored word
module ttl_reg_xcvr
    import ttl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 1,
    parameter int INVERT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] dir,
    input  logic             gab_n,
    input  logic             gba_n,
    input  logic             ldab,
    input  logic             ldba,
    input  logic             sab,
    input  logic             sba
);

    localparam logic [63:0]      INV_FULL = invert_mask(INVERT);
    localparam logic [WIDTH-1:0] INV_MASK = INV_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] rab_q;
    logic [WIDTH-1:0] rba_q;
    logic [WIDTH-1:0] b_val;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_oe;
    logic [WIDTH-1:0] a_oe;

    ttl_xcvr_shreg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ab (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ldab),
        .d     (a),
        .q     (rab_q)
    );

    ttl_xcvr_shreg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ba (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ldba),
        .d     (b),
        .q     (rba_q)
    );

    // Source select, inversion and per-bit enables. A bit can only be
    // enabled toward one bus because dir[i] picks exactly one side.
    always_comb begin
        b_val = (sab ? rab_q : a) ^ INV_MASK;
        a_val = (sba ? rba_q : b) ^ INV_MASK;
        b_oe  = '0;
        a_oe  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b_oe[i] = (dir[i] == XCVR_A2B) && !gab_n;
            a_oe[i] = (dir[i] == XCVR_B2A) && !gba_n;
        end
    end

    // Per-bit tristate pin drivers
    for (genvar i = 0; i < WIDTH; i++) begin : g_pins
        assign b[i] = b_oe[i] ? b_val[i] : 1'bz;
        assign a[i] = a_oe[i] ? a_val[i] : 1'bz;
    end

endmodule

// File: tb/tb_ttl_reg_xcvr.sv
module tb_ttl_reg_xcvr;

    localparam int W1 = 4;
    localparam int D1 = 2;
    localparam int W2 = 8;
    localparam int D2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance 1: WIDTH=4, DEPTH=2, INVERT=1
    wire  [W1-1:0] a1;
    wire  [W1-1:0] b1;
    logic [W1-1:0] dir1;
    logic          gab1_n, gba1_n, ldab1, ldba1, sab1, sba1;
    logic [W1-1:0] a1_ext, b1_ext, a1_tben, b1_tben;

    // Instance 2: WIDTH=8, DEPTH=3, INVERT=0
    wire  [W2-1:0] a2;
    wire  [W2-1:0] b2;
    logic [W2-1:0] dir2;
    logic          gab2_n, gba2_n, ldab2, ldba2, sab2, sba2;
    logic [W2-1:0] a2_ext, b2_ext, a2_tben, b2_tben;

    for (genvar i = 0; i < W1; i++) begin : g_tb1
        assign a1[i] = a1_tben[i] ? a1_ext[i] : 1'bz;
        assign b1[i] = b1_tben[i] ? b1_ext[i] : 1'bz;
    end
    for (genvar i = 0; i < W2; i++) begin : g_tb2
        assign a2[i] = a2_tben[i] ? a2_ext[i] : 1'bz;
        assign b2[i] = b2_tben[i] ? b2_ext[i] : 1'bz;
    end

    ttl_reg_xcvr #(.WIDTH(W1), .DEPTH(D1), .INVERT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .dir(dir1),
        .gab_n(gab1_n), .gba_n(gba1_n), .ldab(ldab1), .ldba(ldba1),
        .sab(sab1), .sba(sba1)
    );

    ttl_reg_xcvr #(.WIDTH(W2), .DEPTH(D2), .INVERT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .dir(dir2),
        .gab_n(gab2_n), .gba_n(gba2_n), .ldab(ldab2), .ldba(ldba2),
        .sab(sab2), .sba(sba2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model for instance 1: index 0 is the newest stored word,
    // index D1-1 is the word presented when a stored source is selected.
    logic [W1-1:0] ab_q[$];
    logic [W1-1:0] ba_q[$];

    // Expected pin values of instance 1: {a, b}. A pin driven by the
    // transceiver shows the (inverted) selected source; any other pin
    // shows the bench's own drive.
    function automatic logic [2*W1-1:0] model_bus();
        logic [W1-1:0] ea, eb;
        for (int i = 0; i < W1; i++) begin
            ea[i] = a1_ext[i];
            eb[i] = b1_ext[i];
            if (dir1[i] && !gab1_n)
                eb[i] = ~(sab1 ? ab_q[D1-1][i] : a1_ext[i]);
            if (!dir1[i] && !gba1_n)
                ea[i] = ~(sba1 ? ba_q[D1-1][i] : b1_ext[i]);
        end
        return {ea, eb};
    endfunction

    task automatic applyStimulus(input logic [W1-1:0] dir, input logic gab_n,
                                 input logic gba_n, input logic sab,
                                 input logic sba, input logic ldab,
                                 input logic ldba, input logic [W1-1:0] a_v,
                                 input logic [W1-1:0] b_v);
        dir1   = dir;
        gab1_n = gab_n;
        gba1_n = gba_n;
        sab1   = sab;
        sba1   = sba;
        ldab1  = ldab;
        ldba1  = ldba;
        a1_ext = a_v;
        b1_ext = b_v;
        for (int i = 0; i < W1; i++) begin
            a1_tben[i] = !(!dir[i] && !gba_n);
            b1_tben[i] = !(dir[i] && !gab_n);
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare instance 1 pins against the model
    task automatic checkModel(input string tag);
        logic [2*W1-1:0] e;
        e = model_bus();
        checkOutput({tag, "_a"}, {4'h0, a1}, {4'h0, e[2*W1-1:W1]});
        checkOutput({tag, "_b"}, {4'h0, b1}, {4'h0, e[W1-1:0]});
    endtask

    // One clock edge; the model captures the pins as they were before it
    task automatic tick();
        logic [2*W1-1:0] seen;
        seen = model_bus();
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < D1; k++) begin
                ab_q[k] = '0;
                ba_q[k] = '0;
            end
        end else begin
            if (ldab1) begin
                ab_q.push_front(seen[2*W1-1:W1]);
                ab_q.delete(D1);
            end
            if (ldba1) begin
                ba_q.push_front(seen[W1-1:0]);
                ba_q.delete(D1);
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < D1; k++) begin
            ab_q.push_back('0);
            ba_q.push_back('0);
        end
        rst_n  = 1'b0;
        dir2   = '0;
        gab2_n = 1'b1;
        gba2_n = 1'b1;
        ldab2  = 1'b0;
        ldba2  = 1'b0;
        sab2   = 1'b0;
        sba2   = 1'b0;
        a2_ext = '0;
        b2_ext = '0;
        a2_tben = '1;
        b2_tben = '1;
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // Isolation: nothing driven, pins keep the external values
        applyStimulus(4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b1010);
        checkOutput("iso_a", {4'h0, a1}, 8'h05);
        checkOutput("iso_b", {4'h0, b1}, 8'h0A);

        // Live transfers, inverted
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b0000);
        checkOutput("live_ab", {4'h0, b1}, 8'h05);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1100);
        checkOutput("live_ba", {4'h0, a1}, 8'h03);
        applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b1000);
        checkOutput("mixed_a", {4'h0, a1}, 8'h03);
        checkOutput("mixed_b", {4'h0, b1}, 8'h0C);

        // Pipeline load, stored select and hold
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, 4'b0000);
        tick();
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, 4'b0000);
        tick();
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0000);
        checkOutput("pipe_first", {4'h0, b1}, 8'h06);
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        tick();
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        checkOutput("pipe_second", {4'h0, b1}, 8'h09);
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("pipe_hold", {4'h0, b1}, 8'h09);
        end

        // Reset while loading wins over ldab
        rst_n = 1'b0;
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000);
        tick();
        checkOutput("rst_mid", {4'h0, b1}, 8'h0F);
        rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0000);
        tick();
        checkOutput("rst_resume1", {4'h0, b1}, 8'h0F);
        tick();
        checkOutput("rst_resume2", {4'h0, b1}, 8'h0C);

        // Wide, non-inverting, three-stage instance
        dir2    = '0;
        gba2_n  = 1'b0;
        sba2    = 1'b1;
        ldba2   = 1'b1;
        b2_ext  = 8'hA5;
        a2_tben = '0;
        b2_tben = '1;
        tick();
        checkOutput("wide_edge1", a2, 8'h00);
        tick();
        checkOutput("wide_edge2", a2, 8'h00);
        tick();
        checkOutput("wide_edge3", a2, 8'hA5);
        ldba2 = 1'b0;
        tick();
        checkOutput("wide_hold", a2, 8'hA5);

        // Randomized traffic against the model
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        for (int n = 0; n < 300; n++) begin
            rst_n = ($urandom_range(0, 15) != 0);
            applyStimulus(4'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 4'($urandom), 4'($urandom));
            checkModel("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
